// File: rtl/branch_resolve_tracker.sv
// Branch resolve tracker: keeps decode-time branch cache predictions in order,
// checks each execute-stage resolution against the oldest one, and drives the
// registered cache update port plus a mispredict redirect to fetch.
module branch_resolve_tracker #(
  parameter int unsigned DEPTH_N = 3
) (
  input  logic        iCLOCK,
  input  logic        iRESET_SYNC,
  input  logic        iFLUSH,
  input  logic        iPRED_STB,
  input  logic [31:0] iPRED_INST_ADDR,
  input  logic        iPRED_HIT,
  input  logic        iPRED_TAKEN,
  input  logic [31:0] iPRED_ADDR,
  output logic        oPRED_FULL,
  input  logic        iRESOLVE_STB,
  input  logic [31:0] iRESOLVE_INST_ADDR,
  input  logic        iRESOLVE_TAKEN,
  input  logic [31:0] iRESOLVE_ADDR,
  output logic        oJUMP_STB,
  output logic        oJUMP_HIT,
  output logic [31:0] oJUMP_ADDR,
  output logic [31:0] oJUMP_INST_ADDR,
  output logic        oMISS_STB,
  output logic [31:0] oMISS_ADDR,
  output logic [31:0] oSTAT_BRANCH,
  output logic [31:0] oSTAT_MISS
);

  localparam int unsigned DEPTH = 1 << DEPTH_N;
  localparam int unsigned PW    = DEPTH_N + 1;

  typedef struct packed {
    logic [31:0] inst_addr;
    logic        hit;
    logic        taken;
    logic [31:0] addr;
  } pred_t;

  pred_t          fifo_q [DEPTH];
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic           full_q, full_d;

  logic           jump_stb_q, jump_hit_q;
  logic [31:0]    jump_addr_q, jump_inst_addr_q;
  logic           miss_stb_q;
  logic [31:0]    miss_addr_q;
  logic [31:0]    stat_branch_q, stat_miss_q;

  logic           empty_c;
  logic           full_c;
  pred_t          head_c;
  logic           match_c;
  logic           pred_taken_c;
  logic           miss_c;
  logic           pop_c;
  logic           push_c;
  logic           resolve_c;

  // Pointer bookkeeping, head match and mispredict detection.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    empty_c      = (rd_ptr_q == wr_ptr_q);
    full_c       = (rd_ptr_q[DEPTH_N] != wr_ptr_q[DEPTH_N]) &&
                   (rd_ptr_q[DEPTH_N-1:0] == wr_ptr_q[DEPTH_N-1:0]);
    head_c       = fifo_q[rd_ptr_q[DEPTH_N-1:0]];
    match_c      = iRESOLVE_STB && !empty_c && (head_c.inst_addr == iRESOLVE_INST_ADDR);
    pred_taken_c = match_c && head_c.hit && head_c.taken;
    miss_c       = iRESOLVE_STB &&
                   ((pred_taken_c != iRESOLVE_TAKEN) ||
                    (pred_taken_c && iRESOLVE_TAKEN && (head_c.addr != iRESOLVE_ADDR)));
    resolve_c    = iRESOLVE_STB && !iFLUSH;
    pop_c        = match_c && !iFLUSH;
    // A push on the wrong path (same cycle as a mispredict) is discarded.
    push_c       = iPRED_STB && (!full_c || pop_c) && !miss_c && !iFLUSH;

    if (iFLUSH) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (miss_c) begin
        rd_ptr_d = wr_ptr_q;
      end else if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end

    full_d = (rd_ptr_d[DEPTH_N] != wr_ptr_d[DEPTH_N]) &&
             (rd_ptr_d[DEPTH_N-1:0] == wr_ptr_d[DEPTH_N-1:0]);
  end

  // Prediction storage; contents are don't-care while outside the pointer window.
  always_ff @(posedge iCLOCK) begin
    if (push_c && !iRESET_SYNC) begin
      fifo_q[wr_ptr_q[DEPTH_N-1:0]] <= '{inst_addr: iPRED_INST_ADDR,
                                         hit:       iPRED_HIT,
                                         taken:     iPRED_TAKEN,
                                         addr:      iPRED_ADDR};
    end
  end

  // Pointers, registered outputs and statistics counters.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      full_q           <= 1'b0;
      jump_stb_q       <= 1'b0;
      jump_hit_q       <= 1'b0;
      jump_addr_q      <= '0;
      jump_inst_addr_q <= '0;
      miss_stb_q       <= 1'b0;
      miss_addr_q      <= '0;
      stat_branch_q    <= '0;
      stat_miss_q      <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      full_q     <= full_d;
      jump_stb_q <= resolve_c;
      miss_stb_q <= resolve_c && miss_c;
      if (resolve_c) begin
        jump_hit_q       <= !iRESOLVE_TAKEN;
        jump_addr_q      <= iRESOLVE_ADDR;
        jump_inst_addr_q <= iRESOLVE_INST_ADDR;
        miss_addr_q      <= iRESOLVE_TAKEN ? iRESOLVE_ADDR : (iRESOLVE_INST_ADDR + 32'h4);
        stat_branch_q    <= stat_branch_q + 32'(1);
        if (miss_c) begin
          stat_miss_q <= stat_miss_q + 32'(1);
        end
      end
    end
  end

  assign oPRED_FULL      = full_q;
  assign oJUMP_STB       = jump_stb_q;
  assign oJUMP_HIT       = jump_hit_q;
  assign oJUMP_ADDR      = jump_addr_q;
  assign oJUMP_INST_ADDR = jump_inst_addr_q;
  assign oMISS_STB       = miss_stb_q;
  assign oMISS_ADDR      = miss_addr_q;
  assign oSTAT_BRANCH    = stat_branch_q;
  assign oSTAT_MISS      = stat_miss_q;

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Directed bench for branch_resolve_tracker with an expected-update scoreboard.
module tb_branch_resolve_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        pred_stb = 1'b0;
  logic [31:0] pred_inst = '0;
  logic        pred_hit = 1'b0;
  logic        pred_taken = 1'b0;
  logic [31:0] pred_addr = '0;
  logic        pred_full;
  logic        res_stb = 1'b0;
  logic [31:0] res_inst = '0;
  logic        res_taken = 1'b0;
  logic [31:0] res_addr = '0;
  logic        jump_stb, jump_hit;
  logic [31:0] jump_addr, jump_inst;
  logic        miss_stb;
  logic [31:0] miss_addr, stat_branch, stat_miss;

  typedef struct {
    logic        hit;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        miss;
    logic [31:0] miss_addr;
  } exp_t;

  exp_t        sb_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] exp_branch = '0;
  logic [31:0] exp_missn  = '0;

  always #5 clk = ~clk;

  branch_resolve_tracker #(.DEPTH_N(3)) dut (
    .iCLOCK             (clk),
    .iRESET_SYNC        (rst),
    .iFLUSH             (flush),
    .iPRED_STB          (pred_stb),
    .iPRED_INST_ADDR    (pred_inst),
    .iPRED_HIT          (pred_hit),
    .iPRED_TAKEN        (pred_taken),
    .iPRED_ADDR         (pred_addr),
    .oPRED_FULL         (pred_full),
    .iRESOLVE_STB       (res_stb),
    .iRESOLVE_INST_ADDR (res_inst),
    .iRESOLVE_TAKEN     (res_taken),
    .iRESOLVE_ADDR      (res_addr),
    .oJUMP_STB          (jump_stb),
    .oJUMP_HIT          (jump_hit),
    .oJUMP_ADDR         (jump_addr),
    .oJUMP_INST_ADDR    (jump_inst),
    .oMISS_STB          (miss_stb),
    .oMISS_ADDR         (miss_addr),
    .oSTAT_BRANCH       (stat_branch),
    .oSTAT_MISS         (stat_miss)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic pred(input logic [31:0] inst, input logic hit, input logic tk,
                      input logic [31:0] addr);
    pred_stb   = 1'b1;
    pred_inst  = inst;
    pred_hit   = hit;
    pred_taken = tk;
    pred_addr  = addr;
  endtask

  task automatic res(input logic [31:0] inst, input logic tk, input logic [31:0] addr);
    res_stb   = 1'b1;
    res_inst  = inst;
    res_taken = tk;
    res_addr  = addr;
  endtask

  // One clock: record the expected update, advance, then compare everything.
  task automatic tick(input logic exp_miss, input logic exp_full);
    exp_t e;
    if (res_stb && !flush) begin
      e.hit       = !res_taken;
      e.addr      = res_addr;
      e.inst      = res_inst;
      e.miss      = exp_miss;
      e.miss_addr = res_taken ? res_addr : res_inst + 32'h4;
      sb_q.push_back(e);
      exp_branch = exp_branch + 32'd1;
      if (exp_miss) exp_missn = exp_missn + 32'd1;
    end
    @(posedge clk);
    #1;
    pred_stb = 1'b0;
    res_stb  = 1'b0;
    flush    = 1'b0;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("jump_stb", 32'(jump_stb), 32'd1);
      chk("jump_hit", 32'(jump_hit), 32'(e.hit));
      chk("jump_addr", jump_addr, e.addr);
      chk("jump_inst", jump_inst, e.inst);
      chk("miss_stb", 32'(miss_stb), 32'(e.miss));
      chk("miss_addr", miss_addr, e.miss_addr);
    end else begin
      chk("jump_stb_idle", 32'(jump_stb), 32'd0);
      chk("miss_stb_idle", 32'(miss_stb), 32'd0);
    end
    chk("pred_full", 32'(pred_full), 32'(exp_full));
    chk("stat_branch", stat_branch, exp_branch);
    chk("stat_miss", stat_miss, exp_missn);
  endtask

  task automatic check_reset_state();
    chk("rst_jump_stb", 32'(jump_stb), 32'd0);
    chk("rst_jump_hit", 32'(jump_hit), 32'd0);
    chk("rst_jump_addr", jump_addr, 32'd0);
    chk("rst_jump_inst", jump_inst, 32'd0);
    chk("rst_miss_stb", 32'(miss_stb), 32'd0);
    chk("rst_miss_addr", miss_addr, 32'd0);
    chk("rst_full", 32'(pred_full), 32'd0);
    chk("rst_branch", stat_branch, 32'd0);
    chk("rst_miss", stat_miss, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state();

    // 1: correctly predicted taken branch
    pred(32'h100, 1'b1, 1'b1, 32'h200); tick(1'b0, 1'b0);
    res(32'h100, 1'b1, 32'h200);        tick(1'b0, 1'b0);

    // 2: predicted not taken, actually taken
    pred(32'h104, 1'b1, 1'b0, 32'h0);   tick(1'b0, 1'b0);
    res(32'h104, 1'b1, 32'h300);        tick(1'b1, 1'b0);

    // 3: mispredict flushes younger entries; next resolve takes mismatch path
    pred(32'h10, 1'b1, 1'b0, 32'h0);    tick(1'b0, 1'b0);
    pred(32'h20, 1'b1, 1'b0, 32'h0);    tick(1'b0, 1'b0);
    pred(32'h30, 1'b1, 1'b0, 32'h0);    tick(1'b0, 1'b0);
    res(32'h10, 1'b1, 32'h80);          tick(1'b1, 1'b0);
    res(32'h20, 1'b0, 32'h0);           tick(1'b0, 1'b0);

    // 4: fill, push+pop while full, dropped push while full, drain
    for (int i = 0; i < 8; i++) begin
      pred(32'h400 + 32'(4 * i), 1'b1, 1'b0, 32'h0);
      tick(1'b0, (i == 7));
    end
    pred(32'h420, 1'b1, 1'b0, 32'h0);
    res(32'h400, 1'b0, 32'h0);          tick(1'b0, 1'b1);
    pred(32'h424, 1'b1, 1'b1, 32'h500); tick(1'b0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      res(32'h400 + 32'(4 * i), 1'b0, 32'h0);
      tick(1'b0, 1'b0);
    end
    // The dropped 0x424 entry is absent, so this resolve mismatches and mispredicts
    res(32'h424, 1'b1, 32'h500);        tick(1'b1, 1'b0);

    // 5: fall-through address wraps
    pred(32'hFFFF_FFFC, 1'b1, 1'b1, 32'h1000); tick(1'b0, 1'b0);
    res(32'hFFFF_FFFC, 1'b0, 32'h0);           tick(1'b1, 1'b0);

    // 6: flush with push+resolve in the same cycle
    pred(32'h600, 1'b1, 1'b1, 32'h700); tick(1'b0, 1'b0);
    flush = 1'b1;
    pred(32'h604, 1'b1, 1'b1, 32'h800);
    res(32'h600, 1'b1, 32'h700);        tick(1'b0, 1'b0);
    // FIFO was emptied, so the retried resolve finds no prediction
    res(32'h600, 1'b1, 32'h700);        tick(1'b1, 1'b0);

    // Reset in the middle of operation with a full FIFO and a pending push
    for (int i = 0; i < 8; i++) begin
      pred(32'h700 + 32'(4 * i), 1'b1, 1'b1, 32'h900);
      tick(1'b0, (i == 7));
    end
    rst = 1'b1;
    pred(32'h720, 1'b1, 1'b1, 32'h900);
    @(posedge clk);
    #1;
    rst = 1'b0;
    pred_stb = 1'b0;
    sb_q.delete();
    exp_branch = '0;
    exp_missn  = '0;
    check_reset_state();
    res(32'h700, 1'b1, 32'h900);        tick(1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
